// File: rtl/heap_pq.sv
// rtl/heap_pq.sv - binary-heap priority queue with min/max mode, push/pop handshakes and drain marker
module heap_pq #(
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = 4,
    parameter int NLEVELS    = 5,
    parameter int MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [NLEVELS-1:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam int CAP = (1 << NLEVELS) - 1;
    localparam logic [NLEVELS-1:0] CAP_N = NLEVELS'(CAP);
    localparam logic [NLEVELS-1:0] ONE   = NLEVELS'(1);
    localparam logic [NLEVELS:0]   ONE_W = (NLEVELS + 1)'(1);

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   entry [CAP];
    logic [NLEVELS-1:0]      idx;
    logic                    draining;

    logic                    push_fire, pop_fire;
    logic [NLEVELS-1:0]      parent;
    logic                    up_swap;
    logic [NLEVELS:0]        lc, rc, bc, cnt_ext;
    logic                    l_ex, r_ex, down_swap;
    logic [NLEVELS-1:0]      bc_n;

    // Ordering ignores payload bits; equal keys are never "better".
    function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
        if (MODE == 0)
            return a[KEY_WIDTH-1:0] < b[KEY_WIDTH-1:0];
        else
            return a[KEY_WIDTH-1:0] > b[KEY_WIDTH-1:0];
    endfunction

    assign full      = (count == CAP_N);
    assign empty     = (count == '0);
    assign in_ready  = (state == IDLE) && !full && !draining && !rst;
    assign out_valid = (state == IDLE) && !empty;
    assign dout      = entry[0];
    assign out_last  = out_valid && draining && (count == ONE);

    assign push_fire = in_valid && in_ready;
    assign pop_fire  = out_valid && out_ready;

    assign parent  = (idx - ONE) >> 1;
    assign up_swap = (idx != '0) && better(entry[idx], entry[parent]);

    // Child indices are one bit wider so that children past CAP never wrap.
    assign cnt_ext   = {1'b0, count};
    assign lc        = {idx, 1'b1};
    assign rc        = lc + ONE_W;
    assign l_ex      = lc < cnt_ext;
    assign r_ex      = rc < cnt_ext;
    assign bc        = (r_ex && better(entry[rc[NLEVELS-1:0]], entry[lc[NLEVELS-1:0]])) ? rc : lc;
    assign bc_n      = bc[NLEVELS-1:0];
    assign down_swap = l_ex && better(entry[bc_n], entry[idx]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push_fire && pop_fire)
                    state_nxt = SIFT_DOWN;
                else if (push_fire)
                    state_nxt = SIFT_UP;
                else if (pop_fire)
                    state_nxt = (count == ONE) ? IDLE : SIFT_DOWN;
            end
            SIFT_UP:   state_nxt = up_swap ? SIFT_UP : IDLE;
            SIFT_DOWN: state_nxt = down_swap ? SIFT_DOWN : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || init)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CAP; i++)
                entry[i] <= '0;
            count    <= '0;
            idx      <= '0;
            draining <= 1'b0;
        end else if (init) begin
            count    <= '0;
            idx      <= '0;
            draining <= 1'b0;
        end else begin
            if (flush && (count != '0))
                draining <= 1'b1;
            if (push_fire && pop_fire) begin
                entry[0] <= din;
                idx      <= '0;
            end else if (push_fire) begin
                entry[count] <= din;
                idx          <= count;
                count        <= count + ONE;
            end else if (pop_fire) begin
                entry[0] <= entry[count - ONE];
                count    <= count - ONE;
                idx      <= '0;
                if (count == ONE)
                    draining <= 1'b0;
            end
            if (state == SIFT_UP && up_swap) begin
                entry[idx]    <= entry[parent];
                entry[parent] <= entry[idx];
                idx           <= parent;
            end
            if (state == SIFT_DOWN && down_swap) begin
                entry[idx]  <= entry[bc_n];
                entry[bc_n] <= entry[idx];
                idx         <= bc_n;
            end
        end
    end

endmodule

// File: tb/tb_heap_pq.sv
// tb/tb_heap_pq.sv - directed self-checking bench for heap_pq (min and max instances)
module tb_heap_pq;

    logic       clk = 1'b0;
    logic       rst;
    logic       init      [2];
    logic       flush     [2];
    logic [7:0] din       [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] dout      [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       out_last  [2];
    logic [2:0] count     [2];
    logic       full      [2];
    logic       empty     [2];

    int checks   = 0;
    int failures = 0;
    bit mon_ir   = 0;
    bit ir_seen  = 0;

    always #5 clk = ~clk;

    heap_pq #(.DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(3), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .init(init[0]), .flush(flush[0]), .din(din[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .dout(dout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0]),
        .count(count[0]), .full(full[0]), .empty(empty[0])
    );

    heap_pq #(.DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(3), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .init(init[1]), .flush(flush[1]), .din(din[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .dout(dout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1]),
        .count(count[1]), .full(full[1]), .empty(empty[1])
    );

    always @(negedge clk)
        if (mon_ir && in_ready[0])
            ir_seen = 1'b1;

    typedef struct {
        bit         is_pop;
        logic [7:0] d;
        logic [2:0] cnt;
        logic       last;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int u, input logic [7:0] d, input logic [2:0] exp_cnt);
        int n = 0;
        din[u] = d;
        in_valid[u] = 1'b1;
        while (!in_ready[u] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(n < 30), 1);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        chk("push_count", 32'(count[u]), 32'(exp_cnt));
    endtask

    task automatic pop(input int u, input logic [7:0] d, input logic last, input logic [2:0] exp_cnt);
        int n = 0;
        out_ready[u] = 1'b1;
        while (!out_valid[u] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("pop_valid", 32'(n < 30), 1);
        chk("pop_dout", 32'(dout[u]), 32'(d));
        chk("pop_last", 32'(out_last[u]), 32'(last));
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        chk("pop_count", 32'(count[u]), 32'(exp_cnt));
    endtask

    task automatic settle(input int u);
        int n = 0;
        while (!(out_valid[u] || count[u] == 3'd0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("settle", 32'(n < 30), 1);
    endtask

    task automatic pulse_flush(input int u);
        @(negedge clk);
        flush[u] = 1'b1;
        @(posedge clk);
        #1;
        flush[u] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            init[u] = 0; flush[u] = 0; din[u] = '0; in_valid[u] = 0; out_ready[u] = 0;
        end

        tbl[0] = '{0, 8'h05, 3'd1, 0};
        tbl[1] = '{0, 8'h02, 3'd2, 0};
        tbl[2] = '{0, 8'h07, 3'd3, 0};
        tbl[3] = '{0, 8'h01, 3'd4, 0};
        tbl[4] = '{0, 8'h03, 3'd5, 0};
        tbl[5] = '{1, 8'h01, 3'd4, 0};
        tbl[6] = '{1, 8'h02, 3'd3, 0};
        tbl[7] = '{1, 8'h03, 3'd2, 0};
        tbl[8] = '{1, 8'h05, 3'd1, 0};
        tbl[9] = '{1, 8'h07, 3'd0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready[0]), 0);
        chk("rst_count", 32'(count[0]), 0);
        chk("rst_empty", 32'(empty[0]), 1);
        chk("rst_full", 32'(full[0]), 0);
        chk("rst_out_valid", 32'(out_valid[0]), 0);
        chk("rst_dout", 32'(dout[0]), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready[0]), 1);

        // min-heap ordering from the vector table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].is_pop) begin
                pop(0, tbl[i].d, tbl[i].last, tbl[i].cnt);
            end else begin
                push(0, tbl[i].d, tbl[i].cnt);
                settle(0);
            end
        end
        chk("s1_empty", 32'(empty[0]), 1);

        // fill to capacity, then a held 8th push
        for (int i = 0; i < 7; i++) begin
            push(0, 8'(9 - i), 3'(i + 1));
        end
        settle(0);
        chk("full_flag", 32'(full[0]), 1);
        chk("full_in_ready", 32'(in_ready[0]), 0);
        din[0] = 8'h00;
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_count", 32'(count[0]), 7);
        pop(0, 8'h03, 0, 3'd6);
        push(0, 8'h00, 3'd7);
        settle(0);
        pop(0, 8'h00, 0, 3'd6);
        for (int i = 0; i < 6; i++) begin
            pop(0, 8'(4 + i), 0, 3'(5 - i));
        end

        // flush drain with producer held valid
        push(0, 8'h04, 3'd1);
        push(0, 8'h01, 3'd2);
        push(0, 8'h06, 3'd3);
        settle(0);
        pulse_flush(0);
        din[0] = 8'h0A;
        in_valid[0] = 1'b1;
        mon_ir = 1'b1;
        pop(0, 8'h01, 0, 3'd2);
        pop(0, 8'h04, 0, 3'd1);
        pop(0, 8'h06, 1, 3'd0);
        mon_ir = 1'b0;
        chk("drain_in_ready_low", 32'(ir_seen), 0);
        chk("post_drain_in_ready", 32'(in_ready[0]), 1);
        in_valid[0] = 1'b0;

        // simultaneous push and pop replaces the root
        push(0, 8'h02, 3'd1);
        push(0, 8'h04, 3'd2);
        push(0, 8'h06, 3'd3);
        settle(0);
        din[0] = 8'h03;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        chk("pp_in_ready", 32'(in_ready[0]), 1);
        chk("pp_out_valid", 32'(out_valid[0]), 1);
        chk("pp_dout", 32'(dout[0]), 32'h02);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        chk("pp_count", 32'(count[0]), 3);
        pop(0, 8'h03, 0, 3'd2);
        pop(0, 8'h04, 0, 3'd1);
        pop(0, 8'h06, 0, 3'd0);

        // max-heap keeps payload with its key
        push(1, 8'hA1, 3'd1);
        push(1, 8'hB9, 3'd2);
        push(1, 8'hC4, 3'd3);
        settle(1);
        pop(1, 8'hB9, 0, 3'd2);
        pop(1, 8'hC4, 0, 3'd1);
        pop(1, 8'hA1, 0, 3'd0);

        // reset in the middle of a sift-down
        push(0, 8'h05, 3'd1);
        push(0, 8'h03, 3'd2);
        push(0, 8'h07, 3'd3);
        push(0, 8'h01, 3'd4);
        settle(0);
        pop(0, 8'h01, 0, 3'd3);
        rst = 1'b1;
        chk("midrst_in_ready", 32'(in_ready[0]), 0);
        @(posedge clk);
        #1;
        chk("midrst_count", 32'(count[0]), 0);
        chk("midrst_empty", 32'(empty[0]), 1);
        chk("midrst_out_valid", 32'(out_valid[0]), 0);
        chk("midrst_dout", 32'(dout[0]), 0);
        chk("midrst_out_last", 32'(out_last[0]), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rel_in_ready", 32'(in_ready[0]), 1);

        // init during a drain
        push(0, 8'h04, 3'd1);
        push(0, 8'h02, 3'd2);
        settle(0);
        pulse_flush(0);
        pop(0, 8'h02, 0, 3'd1);
        settle(0);
        chk("drain_last_pending", 32'(out_last[0]), 1);
        init[0] = 1'b1;
        @(posedge clk);
        #1;
        init[0] = 1'b0;
        chk("init_count", 32'(count[0]), 0);
        chk("init_empty", 32'(empty[0]), 1);
        chk("init_out_valid", 32'(out_valid[0]), 0);
        chk("init_in_ready", 32'(in_ready[0]), 1);
        push(0, 8'h05, 3'd1);
        settle(0);
        pop(0, 8'h05, 0, 3'd0);

        // init and flush together: init wins
        push(0, 8'h03, 3'd1);
        settle(0);
        init[0] = 1'b1;
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        init[0] = 1'b0;
        flush[0] = 1'b0;
        chk("initflush_count", 32'(count[0]), 0);
        push(0, 8'h06, 3'd1);
        settle(0);
        pop(0, 8'h06, 0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
